fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the byte-addressed, combinational-read `instruction_memory`. It owns the program counter and drives it to the memory's `PC` input. Each fetched word is buffered with its address in a small prefetch FIFO and handed to decode over a valid/ready handshake. It supports branch/jump redirect with flush and stops cleanly at the end of the memory image.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, widths and the prefetch entry.
// The optional bounds check is enabled by defining FETCH_BOUNDS_CHECK_EN.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Widened to 33 bits so pc+4 near the top of the address space cannot wrap.
    function automatic logic past_end(input logic [ADDR_W-1:0] pc,
                                      input int unsigned       mem_bytes);
        return ({1'b0, pc} + 33'd4) > {1'b0, mem_bytes};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; supports flush and push+pop when full.
// Head contents come straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t      storage_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = storage_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                storage_q[wr_ptr_q] <= entry_i;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, buffers fetched words and hands them to decode.
// Define FETCH_BOUNDS_CHECK_EN to halt at end of image and fault on out-of-range redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned        MEM_BYTES  = 37,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic               fault
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  target;
    logic               redirect_ok;
    logic               at_end;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       fifo_head;
    fetch_entry_t       fifo_in;
    logic               unused_redirect_lsbs;

    assign target               = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign at_end               = past_end(pc_q, MEM_BYTES);
    assign fifo_pop             = out_valid && out_ready;
    assign fifo_in              = '{instr: imem_instr, pc: pc_q};

`ifdef FETCH_BOUNDS_CHECK_EN
    assign redirect_ok = !past_end(target, MEM_BYTES);
`else
    assign redirect_ok = 1'b1;
`endif

    // Redirects win over everything; a push needs a free slot or a departing head.
    always_comb begin
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                end else if (!at_end && (!fifo_full || fifo_pop)) begin
                    fifo_push = 1'b1;
                end
            end
            HALT: begin
                fifo_flush = redirect_valid;
            end
            default: begin
                fifo_push  = 1'b0;
                fifo_flush = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= RUN;
                end
                RUN, HALT: begin
                    if (redirect_valid) begin
                        if (redirect_ok) begin
                            pc_q    <= target;
                            state_q <= RUN;
                        end else begin
                            state_q <= HALT;
                        end
                    end else if (state_q == RUN && at_end) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                        state_q <= HALT;
`else
                        pc_q    <= RESET_PC;
`endif
                    end else if (fifo_push) begin
                        pc_q <= pc_q + ADDR_W'(4);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (state_q != IDLE && redirect_valid && !redirect_ok) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .entry_i (fifo_in),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_pc   = pc_q;
    assign out_valid = !fifo_empty;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;
    assign halted    = (state_q == HALT) && fifo_empty;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a 20-byte instruction image.
// Expectations adapt to FETCH_BOUNDS_CHECK_EN when it is defined.
module tb_fetch_sequencer;

    localparam int unsigned MEMB  = 20;
    localparam int          DEPTH = 2;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .MEM_BYTES  (MEMB),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h8C41000A;
            32'd4:   return 32'hAC610005;
            32'd8:   return 32'h00A31025;
            32'd12:  return 32'h00C70825;
            32'd16:  return 32'h3061000A;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign imem_instr = memWord(imem_pc);

    // Reference model: a queue of fetched words, a fetch address and a run/halt mode.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mPc;
    int          mMode;
    bit          mFault;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPc    = 32'h0;
        mMode  = 0;
        mFault = 1'b0;
    endtask

    task automatic modelStep(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit     pop;
        longint tgt;
        ent_t   e;
        pop = (mq.size() > 0) && rdy;
        if (mMode == 0) begin
            mMode = 1;
        end else if (rv) begin
            mq.delete();
            tgt = rpc & 32'hFFFF_FFFC;
            if (BOUNDS && (tgt + 4 > MEMB)) begin
                mFault = 1'b1;
                mMode  = 2;
            end else begin
                mPc   = tgt[31:0];
                mMode = 1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (mMode == 1) begin
                if (longint'(mPc) + 4 > MEMB) begin
                    if (BOUNDS) mMode = 2;
                    else mPc = 32'h0;
                end else if (mq.size() < DEPTH) begin
                    e.instr = memWord(mPc);
                    e.pc    = mPc;
                    mq.push_back(e);
                    mPc = mPc + 32'd4;
                end
            end
        end
    endtask

    task automatic modelCompare();
        checkOutput("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("rnd_out_pc", out_pc, mq[0].pc);
            checkOutput("rnd_out_instr", out_instr, mq[0].instr);
        end
        checkOutput("rnd_imem_pc", imem_pc, mPc);
        checkOutput("rnd_halted", 32'(halted), 32'((mMode == 2) && (mq.size() == 0)));
        checkOutput("rnd_fault", 32'(fault), 32'(mFault));
    endtask

    // Drives one cycle of inputs, lets one edge pass and leaves us 1ns after it.
    task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        modelStep(rdy, rv, rpc);
        #1;
    endtask

    task automatic doReset();
        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_imem_pc", imem_pc, 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'h0);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expImem;
        bit          expHalt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'd0,  1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'd0,  32'h8C41000A, 32'd4,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd4,  32'hAC610005, 32'd8,  1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'd8,  32'h00A31025, 32'd12, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd12, 32'h00C70825, 32'd16, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'd16, 32'h3061000A, 32'd20, 1'b0};
`ifdef FETCH_BOUNDS_CHECK_EN
        vecs[6] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'd20, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'd20, 1'b1};
`else
        vecs[6] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'd0,  1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'd0,  32'h8C41000A, 32'd4,  1'b0};
`endif

        // Streaming from reset with decode always ready.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].rdy, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].expInstr);
            end
            checkOutput($sformatf("vec%0d_imem_pc", i), imem_pc, vecs[i].expImem);
            checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].expHalt));
        end

        // Backpressure: head held, PC stalls with the FIFO full, then resumes in order.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bp_first_pc", out_pc, 32'd0);
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_hold_pc", out_pc, 32'd0);
        checkOutput("bp_hold_instr", out_instr, 32'h8C41000A);
        checkOutput("bp_stall_imem", imem_pc, 32'd8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("bp_resume_pc4", out_pc, 32'd4);
        checkOutput("bp_resume_imem", imem_pc, 32'd12);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("bp_resume_pc8", out_pc, 32'd8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("bp_resume_pc12", out_pc, 32'd12);

        // Redirect to an unaligned target while full.
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rdf_full_imem", imem_pc, 32'd8);
        applyStimulus(1'b0, 1'b1, 32'h0000000E);
        checkOutput("rdf_flush_valid", 32'(out_valid), 32'h0);
        checkOutput("rdf_target_imem", imem_pc, 32'd12);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rdf_next_valid", 32'(out_valid), 32'h1);
        checkOutput("rdf_next_pc", out_pc, 32'd12);
        checkOutput("rdf_next_instr", out_instr, 32'h00C70825);

        // Redirect on the same edge as a pop while full: head taken once, rest discarded.
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rdp_head_pc", out_pc, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h4);
        checkOutput("rdp_flush_valid", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("rdp_target_pc", out_pc, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("rdp_follow_pc", out_pc, 32'd8);

        // Out-of-range redirect.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h20);
`ifdef FETCH_BOUNDS_CHECK_EN
        checkOutput("oor_fault", 32'(fault), 32'h1);
        checkOutput("oor_halted", 32'(halted), 32'h1);
        checkOutput("oor_imem_kept", imem_pc, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("oor_still_halted", 32'(halted), 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h0);
        checkOutput("oor_resume_halted", 32'(halted), 32'h0);
        checkOutput("oor_resume_fault", 32'(fault), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("oor_resume_valid", 32'(out_valid), 32'h1);
        checkOutput("oor_resume_pc", out_pc, 32'd0);
        checkOutput("oor_sticky_fault", 32'(fault), 32'h1);
`else
        checkOutput("oor_fault", 32'(fault), 32'h0);
        checkOutput("oor_imem", imem_pc, 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("oor_wrap_imem", imem_pc, 32'd0);
        checkOutput("oor_wrap_valid", 32'(out_valid), 32'h0);
        checkOutput("oor_halted", 32'(halted), 32'h0);
`endif

        // Asynchronous reset in the middle of a stream.
        doReset();
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("ars_pre_valid", 32'(out_valid), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("ars_valid", 32'(out_valid), 32'h0);
        checkOutput("ars_imem", imem_pc, 32'h0);
        checkOutput("ars_out_pc", out_pc, 32'h0);
        checkOutput("ars_out_instr", out_instr, 32'h0);

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            bit          rdy;
            bit          rv;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = 32'hFFFF_FFFC;
                1:       rpc = $urandom;
                default: rpc = 32'($urandom_range(0, 40));
            endcase
            applyStimulus(rdy, rv, rpc);
            modelCompare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
